// File: rtl/if_pc_sequencer_if.sv
// Fetch-control bundle of the IF PC sequencer: stall/redirect requests in,
// fetch PC, qualifiers and region enables out.
interface if_pc_sequencer_if #(
    parameter int XLEN    = 32,
    parameter int N_REDIR = 2
);
    logic                    stall;
    logic [N_REDIR-1:0]      redir_valid;
    logic [N_REDIR*XLEN-1:0] redir_target;
    logic [XLEN-1:0]         pc;
    logic                    pc_valid;
    logic                    flush;
    logic                    redir_pending;
    logic                    bios_en;
    logic                    imem_en;
    logic                    misalign;

    modport master (
        output stall, redir_valid, redir_target,
        input  pc, pc_valid, flush, redir_pending, bios_en, imem_en, misalign
    );

    modport slave (
        input  stall, redir_valid, redir_target,
        output pc, pc_valid, flush, redir_pending, bios_en, imem_en, misalign
    );
endinterface

// File: rtl/if_pc_sequencer.sv
// Instruction-fetch PC sequencer: prioritised redirects vs PC+4, stall-time
// redirect capture/replay, BIOS/IMEM decode. Option: IF_MISALIGN_TRAP_EN.
module if_pc_sequencer #(
    parameter int              XLEN     = 32,
    parameter int              N_REDIR  = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h4000_0000,
    parameter int              BIOS_BIT = 30,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h4000_0100
) (
    input logic              clk,
    input logic              rst,
    if_pc_sequencer_if.slave bus
);
    localparam int IDXW = (N_REDIR > 1) ? $clog2(N_REDIR) : 1;

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_tgt;
    logic [IDXW-1:0] pend_idx;
    logic            flush_q;
    logic            mis_q;

    logic            win;
    logic [IDXW-1:0] win_idx;
    logic [XLEN-1:0] win_raw;
    logic [XLEN-1:0] win_tgt;
    logic            live_ok;
    logic [XLEN-1:0] sel_tgt;
    logic [XLEN-1:0] sel_pc;
    logic            sel_mis;

    // Descending scan so the lowest asserted index is the last one written.
    always_comb begin
        win     = 1'b0;
        win_idx = '0;
        win_raw = '0;
        for (int i = N_REDIR - 1; i >= 0; i--) begin
            if (bus.redir_valid[i]) begin
                win     = 1'b1;
                win_idx = IDXW'(i);
                win_raw = bus.redir_target[i*XLEN +: XLEN];
            end
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    // Keep raw low bits so a replayed capture can still be checked.
    assign win_tgt = win_raw;
`else
    assign win_tgt = win_raw & ~XLEN'(3);
`endif

    assign live_ok = win && (win_idx <= pend_idx);
    assign sel_tgt = (state == HOLD && !live_ok) ? pend_tgt : win_tgt;

`ifdef IF_MISALIGN_TRAP_EN
    assign sel_mis = |sel_tgt[1:0];
    assign sel_pc  = sel_mis ? TRAP_VEC : sel_tgt;
`else
    assign sel_mis = 1'b0;
    assign sel_pc  = sel_tgt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            pc_q     <= RESET_PC;
            pend_tgt <= '0;
            pend_idx <= '0;
            flush_q  <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (!bus.stall) begin
                        if (win) begin
                            pc_q    <= sel_pc;
                            flush_q <= 1'b1;
                            mis_q   <= sel_mis;
                        end else begin
                            pc_q <= pc_q + XLEN'(4);
                        end
                    end else if (win) begin
                        pend_tgt <= win_tgt;
                        pend_idx <= win_idx;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.stall) begin
                        if (live_ok) begin
                            pend_tgt <= win_tgt;
                            pend_idx <= win_idx;
                        end
                    end else begin
                        pc_q     <= sel_pc;
                        flush_q  <= 1'b1;
                        mis_q    <= sel_mis;
                        pend_tgt <= '0;
                        pend_idx <= '0;
                        state    <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_valid      = (state != BOOT);
    assign bus.flush         = flush_q;
    assign bus.redir_pending = (state == HOLD);
    assign bus.bios_en       = pc_q[BIOS_BIT];
    assign bus.imem_en       = ~pc_q[BIOS_BIT];
    assign bus.misalign      = mis_q;
endmodule

// File: tb/tb_if_pc_sequencer.sv
// Directed table-driven bench for if_pc_sequencer, plus a hand-written
// asynchronous-reset-during-HOLD sequence.
module tb_if_pc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    if_pc_sequencer_if #(.XLEN(32), .N_REDIR(2)) bus();

    if_pc_sequencer #(
        .XLEN(32), .N_REDIR(2), .RESET_PC(32'h4000_0000),
        .BIOS_BIT(30), .TRAP_VEC(32'h4000_0100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef IF_MISALIGN_TRAP_EN
    localparam bit          TRAP  = 1'b1;
    localparam logic [31:0] MIS_A = 32'h4000_0100;
    localparam logic [31:0] MIS_B = 32'h4000_0100;
`else
    localparam bit          TRAP  = 1'b0;
    localparam logic [31:0] MIS_A = 32'h0000_0100;
    localparam logic [31:0] MIS_B = 32'h0000_0200;
`endif

    typedef struct {
        logic        st;
        logic [1:0]  rv;
        logic [31:0] t0;
        logic [31:0] t1;
        logic [31:0] pc;
        logic        fl;
        logic        pend;
        logic        mis;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [1:0] rv, input logic [31:0] t0,
                       input logic [31:0] t1, input logic [31:0] pc, input logic fl,
                       input logic pend, input logic mis);
        vec_t v;
        v.st = st; v.rv = rv; v.t0 = t0; v.t1 = t1;
        v.pc = pc; v.fl = fl; v.pend = pend; v.mis = mis;
        vq.push_back(v);
    endtask

    task automatic drive(input logic st, input logic [1:0] rv, input logic [31:0] t0,
                         input logic [31:0] t1);
        bus.stall        = st;
        bus.redir_valid  = rv;
        bus.redir_target = {t1, t0};
    endtask

    initial begin
        drive(1'b0, 2'b00, 32'h0, 32'h0);

        //   st  rv     t0            t1            pc            fl pend mis
        add(0, 2'b00, 32'h0,        32'h0,        32'h4000_0000, 0, 0, 0); // BOOT->RUN, no advance
        add(0, 2'b00, 32'h0,        32'h0,        32'h4000_0004, 0, 0, 0);
        add(0, 2'b00, 32'h0,        32'h0,        32'h4000_0008, 0, 0, 0);
        add(0, 2'b00, 32'h0,        32'h0,        32'h4000_000C, 0, 0, 0);
        add(0, 2'b11, 32'h100,      32'h200,      32'h0000_0100, 1, 0, 0); // src0 beats src1
        add(0, 2'b00, 32'h0,        32'h0,        32'h0000_0104, 0, 0, 0);
        add(1, 2'b00, 32'h0,        32'h0,        32'h0000_0104, 0, 0, 0); // plain stall
        add(1, 2'b10, 32'h0,        32'h300,      32'h0000_0104, 0, 1, 0);
        add(1, 2'b01, 32'h500,      32'h0,        32'h0000_0104, 0, 1, 0); // higher prio overwrites
        add(1, 2'b00, 32'h0,        32'h0,        32'h0000_0104, 0, 1, 0);
        add(0, 2'b00, 32'h0,        32'h0,        32'h0000_0500, 1, 0, 0); // replay
        add(0, 2'b00, 32'h0,        32'h0,        32'h0000_0504, 0, 0, 0);
        add(1, 2'b01, 32'h500,      32'h0,        32'h0000_0504, 0, 1, 0);
        add(0, 2'b10, 32'h0,        32'h600,      32'h0000_0500, 1, 0, 0); // live lower prio loses
        add(0, 2'b01, 32'h700,      32'h0,        32'h0000_0700, 1, 0, 0); // back-to-back flush
        add(1, 2'b01, 32'h800,      32'h0,        32'h0000_0700, 0, 1, 0);
        add(1, 2'b10, 32'h0,        32'h900,      32'h0000_0700, 0, 1, 0); // ignored in HOLD
        add(0, 2'b00, 32'h0,        32'h0,        32'h0000_0800, 1, 0, 0);
        add(0, 2'b10, 32'h0,        32'h102,      MIS_A,         1, 0, TRAP);
        add(0, 2'b00, 32'h0,        32'h0,        MIS_A + 32'd4, 0, 0, 0);
        add(1, 2'b10, 32'h0,        32'h203,      MIS_A + 32'd4, 0, 1, 0);
        add(0, 2'b00, 32'h0,        32'h0,        MIS_B,         1, 0, TRAP); // replayed misaligned
        add(0, 2'b01, 32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 1, 0, 0);
        add(0, 2'b00, 32'h0,        32'h0,        32'h0000_0000, 0, 0, 0); // wrap
        add(1, 2'b10, 32'h0,        32'hA00,      32'h0000_0000, 0, 1, 0);
        add(0, 2'b10, 32'h0,        32'hB00,      32'h0000_0B00, 1, 0, 0); // equal prio live wins

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",       bus.pc,            32'h4000_0000);
        chk("rst_pc_valid", 32'(bus.pc_valid), 32'd0);
        chk("rst_flush",    32'(bus.flush),    32'd0);
        chk("rst_pending",  32'(bus.redir_pending), 32'd0);
        chk("rst_misalign", 32'(bus.misalign), 32'd0);
        chk("rst_bios",     32'(bus.bios_en),  32'd1);
        chk("rst_imem",     32'(bus.imem_en),  32'd0);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vq[i].st, vq[i].rv, vq[i].t0, vq[i].t1);
            @(posedge clk);
            #1;
            chk($sformatf("r%0d_pc", i),       bus.pc,                 vq[i].pc);
            chk($sformatf("r%0d_valid", i),    32'(bus.pc_valid),      32'd1);
            chk($sformatf("r%0d_flush", i),    32'(bus.flush),         32'(vq[i].fl));
            chk($sformatf("r%0d_pending", i),  32'(bus.redir_pending), 32'(vq[i].pend));
            chk($sformatf("r%0d_misalign", i), 32'(bus.misalign),      32'(vq[i].mis));
            chk($sformatf("r%0d_bios", i),     32'(bus.bios_en),       32'(vq[i].pc[30]));
            chk($sformatf("r%0d_imem", i),     32'(bus.imem_en),       32'(!vq[i].pc[30]));
        end

        // Capture a redirect under stall, then hit reset mid-cycle.
        @(negedge clk);
        drive(1'b1, 2'b01, 32'hC00, 32'h0);
        @(posedge clk);
        #1;
        chk("hold_pc",      bus.pc,                 32'h0000_0B00);
        chk("hold_pending", 32'(bus.redir_pending), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc",      bus.pc,                 32'h4000_0000);
        chk("arst_pending", 32'(bus.redir_pending), 32'd0);
        chk("arst_valid",   32'(bus.pc_valid),      32'd0);
        chk("arst_flush",   32'(bus.flush),         32'd0);
        @(negedge clk);
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reboot_pc",    bus.pc,            32'h4000_0000);
        chk("reboot_valid", 32'(bus.pc_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("reboot_pc4",   bus.pc,            32'h4000_0004);
        chk("reboot_flush", 32'(bus.flush),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_pc_sequencer.md
Name: if_pc_sequencer

Overview:
Instruction-fetch PC sequencer. It owns the fetch PC register and arbitrates N prioritised redirect sources (e.g. branch mispredict, predicted target, trap) against sequential PC+4. Redirects that arrive during a stall are held in a pending latch and replayed when the stall releases. It also drives the BIOS/IMEM fetch-region enables for the instruction memories.

Parameters:
XLEN, 32, PC/target width
N_REDIR, 2, number of redirect sources; index 0 = highest priority
RESET_PC, 32'h4000_0000, PC loaded on reset
BIOS_BIT, 30, PC bit selecting BIOS (1) vs IMEM (0) region
TRAP_VEC, 32'h4000_0100, destination for misaligned redirects (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  fetch stage must hold PC this cycle
redir_valid  in  N_REDIR  per-source redirect request
redir_target  in  N_REDIR*XLEN  packed targets; source i at [i*XLEN +: XLEN]
pc  out  XLEN  current fetch PC
pc_valid  out  1  pc is a valid fetch request
flush  out  1  one-cycle pulse: pc just loaded a redirect, squash younger fetches
redir_pending  out  1  a captured redirect is waiting for stall release
bios_en  out  1  pc[BIOS_BIT]==1
imem_en  out  1  pc[BIOS_BIT]==0
misalign  out  1  one-cycle pulse, misaligned redirect taken (0 when feature off)

Behaviour:
- Reset (async, any time, including mid-stall or with pending set): pc=RESET_PC, pc_valid=0, flush=0, redir_pending=0, misalign=0. FSM state = BOOT.
- FSM states: BOOT, RUN, HOLD.
- BOOT -> RUN on the first clk edge after rst deasserts. pc_valid=1 from then on. pc does not advance on that edge.
- Winner select (combinational): lowest index i with redir_valid[i]=1. The winning target's bits [1:0] are forced to 0.
- RUN, stall=0:
  - Live winner: pc<=target; flush=1 next cycle.
  - Otherwise: pc<=pc+4, modulo 2^XLEN (wraps 0xFFFF_FFFC -> 0x0).
- RUN, stall=1:
  - pc holds.
  - Live winner: capture target and index into the pending latch; -> HOLD.
- HOLD, stall=1:
  - pc holds.
  - New winner with index <= stored index overwrites the latch; a lower-priority winner is ignored.
- HOLD, stall=0:
  - Live winner with index <= stored index: pc<=live target. Otherwise pc<=pending target.
  - flush=1 next cycle; latch cleared; -> RUN.
- redir_pending=1 exactly while in HOLD.
- flush is registered: high for exactly the first cycle the new pc is visible. Back-to-back redirects give consecutive flush cycles.
- bios_en and imem_en decode the registered pc combinationally. Exactly one of them is 1 at all times.
- No combinational path from redir_* or stall to pc.

Optional Feature:
IF_MISALIGN_TRAP_EN
- Defined: a winning target with [1:0]!=0 is not forced aligned. pc loads TRAP_VEC instead, with flush=1 and misalign=1 in the same cycle. A misaligned target captured in HOLD is checked when replayed.
- Undefined: low bits are forced to 0 silently; misalign is tied to 0.

Test Plan:
- Reset, release, no stall for 4 cycles -> pc_valid rises after the first edge; pc sequence 0x4000_0000, 0x4000_0004, 0x4000_0008, 0x4000_000C; bios_en=1, flush=0.
- redir_valid=2'b11, targets[0]=0x0000_0100, targets[1]=0x0000_0200, stall=0 -> pc=0x100 next cycle, flush=1 for one cycle, imem_en=1.
- Stall=1; redir_valid[1] with target 0x300; next cycle redir_valid[0] with target 0x500; stall held 3 cycles then released -> pc holds throughout, redir_pending=1, then pc=0x500 with a single flush.
- In HOLD with pending source 0 = 0x500, source 1 fires 0x600 at release -> pc=0x500 (the lower-priority live request loses).
- pc=0xFFFF_FFFC, no redirect -> pc=0x0000_0000, imem_en=1. Then rst pulsed mid-stall with pending set -> pc=RESET_PC, redir_pending=0 immediately (async).
- With IF_MISALIGN_TRAP_EN defined, redirect target 0x0000_0102 -> pc=TRAP_VEC, misalign=1 and flush=1 for one cycle. Without the macro, pc=0x0000_0100 and misalign=0.
